hdmi_timing_gen: RTL and testbench

Raster timing generator for the 640x480@60 HDMI/VGA path. It produces the `hdmi_pix_x`/`hdmi_pix_y` coordinates, `hsync`/`vsync` and `video_on` that drive the game graphics top, its overlay logic and the output encoder. It sits directly upstream of the graphics top. It replaces the disabled `vga_sync` path with one counter pair shared by all pixel consumers.

---
 rtl/hdmi_timing_pkg.sv | 36 +++
 rtl/hdmi_timing_gen_pixel_tick_div.sv | 36 +++
 rtl/hdmi_timing_gen.sv | 142 ++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared 640x480@60 raster constants for the HDMI path and the graphics top
// that consumes its coordinates.
package hdmi_timing_pkg;

  // Default 640x480@60 timing, pixels / lines
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Coordinate width; 10 bits covers totals up to 1024
  localparam int COORD_W = 10;

  // Border-frame coordinates used by the graphics top (outer/inner edges)
  localparam int BRD_X_OUT_L = 150;
  localparam int BRD_X_IN_L  = 160;
  localparam int BRD_X_IN_R  = 480;
  localparam int BRD_X_OUT_R = 490;
  localparam int BRD_Y_OUT_T = 110;
  localparam int BRD_Y_IN_T  = 120;
  localparam int BRD_Y_IN_B  = 360;
  localparam int BRD_Y_OUT_B = 370;

  // Half-open window test lo <= v < hi
  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/hdmi_timing_gen_pixel_tick_div.sv
// Pixel-enable divider: div_cnt runs 0..CLK_DIV-1 and p_tick is registered
// so that it is high in the same cycle that div_cnt sits at CLK_DIV-1.
module pixel_tick_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int CW = 4;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pixel_tick_div: CLK_DIV must be in 1..16");
  end

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_nxt;

  // Next divider count, wrapping at CLK_DIV-1
  always_comb begin
    div_nxt = (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + CW'(1);
  end

  // Divider state and strobe, decoded from the next count so it stays aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      p_tick  <= (div_nxt == CW'(CLK_DIV - 1));
    end
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator for the 640x480@60 HDMI/VGA path. One x/y counter
// pair feeds every pixel consumer. Syncs and video_on are decoded from the
// next-state counters so they line up with hdmi_pix_x/hdmi_pix_y.
// Build option: HDMI_TIMING_PIPE_EN adds one register stage on hsync, vsync
// and video_on for consumers that register rgb one cycle after decoding.
module hdmi_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_NEG = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] hdmi_pix_x,
  output logic [COORD_W-1:0] hdmi_pix_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_cnt
);

  localparam int   H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HS_BEG    = H_ACTIVE + H_FP;
  localparam int   HS_END    = HS_BEG + H_SYNC;
  localparam int   VS_BEG    = V_ACTIVE + V_FP;
  localparam int   VS_END    = VS_BEG + V_SYNC;
  localparam logic SYNC_IDLE = (SYNC_NEG != 0);

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("hdmi_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               x_wrap;
  logic               y_wrap;
  logic               hs_act;
  logic               vs_act;
  logic               vid_nxt;
  logic               hsync_p0;
  logic               vsync_p0;
  logic               video_on_p0;

  // Next-state coordinates and the decodes taken from them
  always_comb begin
    x_wrap = (hdmi_pix_x == COORD_W'(H_TOT - 1));
    y_wrap = (hdmi_pix_y == COORD_W'(V_TOT - 1));
    x_nxt  = hdmi_pix_x;
    y_nxt  = hdmi_pix_y;
    if (p_tick) begin
      x_nxt = x_wrap ? '0 : hdmi_pix_x + COORD_W'(1);
      if (x_wrap) begin
        y_nxt = y_wrap ? '0 : hdmi_pix_y + COORD_W'(1);
      end
    end
    hs_act  = in_window(int'(x_nxt), HS_BEG, HS_END);
    vs_act  = in_window(int'(y_nxt), VS_BEG, VS_END);
    vid_nxt = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
  end

  // Counters, wrap pulses and frame count; pulses share the edge that loads 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdmi_pix_x  <= '0;
      hdmi_pix_y  <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hdmi_pix_x  <= x_nxt;
      hdmi_pix_y  <= y_nxt;
      line_start  <= p_tick && x_wrap;
      frame_start <= p_tick && x_wrap && y_wrap;
      if (p_tick && x_wrap && y_wrap) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // ---- stage p0: decode registered alongside the coordinates ----
  // Sync and blanking decode at the configured polarity
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_p0    <= SYNC_IDLE;
      vsync_p0    <= SYNC_IDLE;
      video_on_p0 <= 1'b0;
    end else begin
      hsync_p0    <= hs_act ^ SYNC_IDLE;
      vsync_p0    <= vs_act ^ SYNC_IDLE;
      video_on_p0 <= vid_nxt;
    end
  end

`ifdef HDMI_TIMING_PIPE_EN
  logic hsync_p1;
  logic vsync_p1;
  logic video_on_p1;

  // ---- stage p1: decode delayed one clk behind the coordinates ----
  // Extra stage to match a consumer that registers rgb after decoding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_p1    <= SYNC_IDLE;
      vsync_p1    <= SYNC_IDLE;
      video_on_p1 <= 1'b0;
    end else begin
      hsync_p1    <= hsync_p0;
      vsync_p1    <= vsync_p0;
      video_on_p1 <= video_on_p0;
    end
  end

  assign hsync    = hsync_p1;
  assign vsync    = vsync_p1;
  assign video_on = video_on_p1;
`else
  assign hsync    = hsync_p0;
  assign vsync    = vsync_p0;
  assign video_on = video_on_p0;
`endif

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen. Three instances share one clock:
// A = default 640x480, CLK_DIV=1; B = default timing, CLK_DIV=4;
// C = tiny 8x8 raster (64 clocks/frame) for frame-level and reset behaviour.
module tb_hdmi_timing_gen;

`ifdef HDMI_TIMING_PIPE_EN
  localparam int PD = 1;
`else
  localparam int PD = 0;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;

  logic       a_pt, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_pt, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;
  logic       c_pt, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [7:0] c_fc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hdmi_timing_gen u_a (
    .clk(clk), .reset(rst_a), .p_tick(a_pt), .hdmi_pix_x(a_x), .hdmi_pix_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_start(a_ls),
    .frame_start(a_fs), .frame_cnt(a_fc)
  );

  hdmi_timing_gen #(.CLK_DIV(4)) u_b (
    .clk(clk), .reset(rst_b), .p_tick(b_pt), .hdmi_pix_x(b_x), .hdmi_pix_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_start(b_ls),
    .frame_start(b_fs), .frame_cnt(b_fc)
  );

  hdmi_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_c (
    .clk(clk), .reset(rst_c), .p_tick(c_pt), .hdmi_pix_x(c_x), .hdmi_pix_y(c_y),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .line_start(c_ls),
    .frame_start(c_fs), .frame_cnt(c_fc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   hs_cnt, hs_first, hs_last, von_fall;
    int   ls_cnt, ls_first, ls_gap, ls_x, ls_y;
    int   pt_cnt, pt_bad, last_chg, prev_x, gap_min, gap_max;
    int   vs_cnt, vs_fx, vs_fy, fs_cnt, fs_first, fs_gap, fs_x, fs_y, fs_fc;
    int   n, pulse_cnt;
    logic prev_von;

    // ---------------- reset hold ----------------
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (3) step();
    check("rst_hsync", 32'(a_hs), 1);
    check("rst_vsync", 32'(a_vs), 1);
    check("rst_video_on", 32'(a_von), 0);
    check("rst_x", 32'(a_x), 0);
    check("rst_y", 32'(a_y), 0);
    check("rst_p_tick", 32'(a_pt), 0);
    check("rst_line_start", 32'(a_ls), 0);
    check("rst_frame_start", 32'(a_fs), 0);
    check("rst_frame_cnt", 32'(a_fc), 0);

    // ---------------- release A, CLK_DIV=1 ----------------
    rst_a = 1'b1;
    step();
    check("a_e1_video_on", 32'(a_von), (PD == 0) ? 1 : 0);
    check("a_e1_x", 32'(a_x), 0);
    check("a_e1_y", 32'(a_y), 0);
    check("a_e1_p_tick", 32'(a_pt), 1);
    step();
    check("a_e2_x", 32'(a_x), 1);
    check("a_e2_video_on", 32'(a_von), 1);

    // Edges 3..1702: x = edge-1 mod 800
    hs_cnt = 0; hs_first = -1; hs_last = -1; von_fall = -1; prev_von = a_von;
    ls_cnt = 0; ls_first = -1; ls_gap = -1; ls_x = -1; ls_y = -1;
    for (int i = 3; i <= 1702; i++) begin
      step();
      if (i <= 802 && a_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_x);
        hs_last = int'(a_x);
      end
      if (prev_von === 1'b1 && a_von === 1'b0 && von_fall < 0) von_fall = int'(a_x);
      prev_von = a_von;
      if (a_ls === 1'b1) begin
        ls_cnt++;
        if (ls_cnt == 1) begin
          ls_first = i; ls_x = int'(a_x); ls_y = int'(a_y);
        end else begin
          ls_gap = i - ls_first;
        end
      end
    end
    check("a_hsync_low_clocks", hs_cnt, 96);
    check("a_hsync_first_x", hs_first, 656 + PD);
    check("a_hsync_last_x", hs_last, 751 + PD);
    check("a_video_on_fall_x", von_fall, 640 + PD);
    check("a_line_start_count", ls_cnt, 2);
    check("a_line_start_first_edge", ls_first, 801);
    check("a_line_start_period", ls_gap, 800);
    check("a_line_start_x", ls_x, 0);
    check("a_line_start_y", ls_y, 1);

    // ---------------- release B, CLK_DIV=4 ----------------
    rst_b = 1'b1;
    pt_cnt = 0; pt_bad = 0; last_chg = -1; prev_x = int'(b_x);
    gap_min = 1000000; gap_max = 0; ls_cnt = 0; ls_first = -1; ls_gap = -1;
    for (int i = 1; i <= 6500; i++) begin
      step();
      if (i <= 400) begin
        if (b_pt === 1'b1) pt_cnt++;
        if (b_pt !== ((i % 4) == 3)) pt_bad++;
      end
      if (int'(b_x) != prev_x) begin
        if (last_chg > 0) begin
          if (i - last_chg < gap_min) gap_min = i - last_chg;
          if (i - last_chg > gap_max) gap_max = i - last_chg;
        end
        last_chg = i;
        prev_x = int'(b_x);
      end
      if (b_ls === 1'b1) begin
        ls_cnt++;
        if (ls_cnt == 1) ls_first = i;
        else ls_gap = i - ls_first;
      end
    end
    check("b_p_tick_count_400", pt_cnt, 100);
    check("b_p_tick_phase_errors", pt_bad, 0);
    check("b_x_step_min", gap_min, 4);
    check("b_x_step_max", gap_max, 4);
    check("b_line_start_first_edge", ls_first, 3200);
    check("b_line_period", ls_gap, 3200);

    // ---------------- release C, tiny raster ----------------
    rst_c = 1'b1;
    vs_cnt = 0; vs_fx = -1; vs_fy = -1;
    fs_cnt = 0; fs_first = -1; fs_gap = -1; fs_x = -1; fs_y = -1; fs_fc = -1;
    for (int i = 1; i <= 140; i++) begin
      step();
      if (c_vs === 1'b0) begin
        vs_cnt++;
        if (vs_fy < 0) begin vs_fx = int'(c_x); vs_fy = int'(c_y); end
      end
      if (c_fs === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 1) begin
          fs_first = i; fs_x = int'(c_x); fs_y = int'(c_y); fs_fc = int'(c_fc);
        end else begin
          fs_gap = i - fs_first;
        end
      end
    end
    check("c_vsync_low_clocks", vs_cnt, 32);
    check("c_vsync_first_y", vs_fy, 5);
    check("c_vsync_first_x", vs_fx, PD);
    check("c_frame_start_count", fs_cnt, 2);
    check("c_frame_start_first_edge", fs_first, 65);
    check("c_frame_period", fs_gap, 64);
    check("c_frame_start_x", fs_x, 0);
    check("c_frame_start_y", fs_y, 0);
    check("c_frame_cnt_first", fs_fc, 1);
    check("c_frame_cnt_second", 32'(c_fc), 2);

    // frame_cnt wrap 255 -> 0
    n = 0;
    while (c_fc !== 8'd255 && n < 20000) begin step(); n++; end
    check("c_frame_cnt_reach_255", 32'(c_fc), 255);
    n = 0;
    do begin step(); n++; end while (c_fs !== 1'b1 && n < 200);
    check("c_frame_start_at_wrap", 32'(c_fs), 1);
    check("c_frame_cnt_wrap", 32'(c_fc), 0);

    // ---------------- async reset mid-frame at (5,6) ----------------
    n = 0;
    while (!(c_x === 10'd5 && c_y === 10'd6) && n < 200) begin step(); n++; end
    check("c_mid_x_reached", 32'(c_x), 5);
    check("c_mid_y_reached", 32'(c_y), 6);
    check("c_mid_vsync_active", 32'(c_vs), 0);
    rst_c = 1'b0;
    #1;
    check("c_async_x", 32'(c_x), 0);
    check("c_async_y", 32'(c_y), 0);
    check("c_async_vsync", 32'(c_vs), 1);
    check("c_async_hsync", 32'(c_hs), 1);
    check("c_async_video_on", 32'(c_von), 0);
    check("c_async_p_tick", 32'(c_pt), 0);
    check("c_async_frame_cnt", 32'(c_fc), 0);
    pulse_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (c_ls !== 1'b0 || c_fs !== 1'b0) pulse_cnt++;
    end
    check("c_hold_no_pulse", pulse_cnt, 0);
    rst_c = 1'b1;
    step();
    check("c_rel_e1_x", 32'(c_x), 0);
    check("c_rel_e1_y", 32'(c_y), 0);
    check("c_rel_e1_p_tick", 32'(c_pt), 1);
    check("c_rel_e1_frame_start", 32'(c_fs), 0);
    check("c_rel_e1_line_start", 32'(c_ls), 0);
    step();
    check("c_rel_e2_x", 32'(c_x), 1);
    pulse_cnt = 0;
    for (int i = 3; i <= 8; i++) begin
      step();
      if (c_ls !== 1'b0 || c_fs !== 1'b0) pulse_cnt++;
    end
    check("c_rel_no_early_pulse", pulse_cnt, 0);
    step();
    check("c_rel_e9_line_start", 32'(c_ls), 1);
    check("c_rel_e9_x", 32'(c_x), 0);
    check("c_rel_e9_y", 32'(c_y), 1);
    check("c_rel_frame_cnt", 32'(c_fc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
